cache_mem_arbiter: RTL and testbench

- Shares one single-beat AXI4 memory master port between the instruction cache miss path and the data cache miss/writeback path.
- Sequences each transaction through AR/R or AW/W/B and returns data with a hold-until-acknowledged handshake.
- Drives the per-requester busy flags that the caches use to stall while the port serves the other side.
- Sits between i_cache/d_cache and the AXI4 bridge.

---
 rtl/defines_axi4.sv | 37 +++
 rtl/cache_arb_rr.sv | 44 ++++
 rtl/cache_mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/defines_axi4.sv
// +------------------------------------------------------------------------+
// | defines_axi4 : shared encodings for the cache/memory arbiter             |
// | Revision     : 1.0                                                       |
// +------------------------------------------------------------------------+
`default_nettype none

package defines_axi4;

  typedef enum logic [8:0] {
    IDLE   = 9'b0_0000_0001,
    I_AR   = 9'b0_0000_0010,
    I_R    = 9'b0_0000_0100,
    I_DONE = 9'b0_0000_1000,
    D_AR   = 9'b0_0001_0000,
    D_R    = 9'b0_0010_0000,
    D_AW   = 9'b0_0100_0000,
    D_B    = 9'b0_1000_0000,
    D_DONE = 9'b1_0000_0000
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // EXOKAY is never expected from a non-exclusive access, so anything but OKAY flags.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_arb_rr.sv
// +------------------------------------------------------------------------+
// | cache_arb_rr : 2-way i/d pick with round-robin or fixed d priority       |
// | Revision     : 1.0                                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module cache_arb_rr
  import defines_axi4::*;
#(
  parameter int RR_EN = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_req_i,
  input  logic     i_req_d,
  input  logic     i_upd,
  input  arb_gnt_t i_upd_gnt,
  output arb_gnt_t o_gnt,
  output logic     o_any
);

  arb_gnt_t r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= GNT_I;
    end else if (i_upd) begin
      r_last <= i_upd_gnt;
    end
  end

  always_comb begin
    o_any = i_req_i | i_req_d;
    o_gnt = GNT_I;
    if (i_req_i && i_req_d) begin
      o_gnt = ((RR_EN == 0) || (r_last == GNT_I)) ? GNT_D : GNT_I;
    end else if (i_req_d) begin
      o_gnt = GNT_D;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// +------------------------------------------------------------------------+
// | cache_mem_arbiter : shares one single-beat AXI4 master between the      |
// |                     icache miss path and the dcache miss/writeback path |
// | Revision          : 1.0                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module cache_mem_arbiter
  import defines_axi4::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RR_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read_ena,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_data,
  output logic                i_valid,
  input  logic                i_read_resp,
  output logic                arb_working_ti,
  input  logic                d_read_ena,
  input  logic                d_write_ena,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  input  logic                d_resp,
  output logic                arb_working_td,
  output logic                d_err,
  output logic                i_err,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  arb_state_t          r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_idata;
  logic [DATA_W-1:0]   r_drdata;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_ivalid;
  logic                r_dvalid;
  logic                r_ierr;
  logic                r_derr;
  logic                r_busy_ti;
  logic                r_busy_td;

  arb_gnt_t            w_gnt;
  arb_gnt_t            w_upd_gnt;
  logic                w_any;
  logic                w_upd;
  logic                w_aw_done;
  logic                w_w_done;

  assign w_upd     = ((r_state == I_DONE) && i_read_resp) || ((r_state == D_DONE) && d_resp);
  assign w_upd_gnt = (r_state == D_DONE) ? GNT_D : GNT_I;
  // A channel counts as done once its valid has dropped or its ready arrives now.
  assign w_aw_done = !r_awvalid || m_awready;
  assign w_w_done  = !r_wvalid  || m_wready;

  cache_arb_rr #(
    .RR_EN(RR_EN)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .i_req_i   (i_read_ena),
    .i_req_d   (d_read_ena | d_write_ena),
    .i_upd     (w_upd),
    .i_upd_gnt (w_upd_gnt),
    .o_gnt     (w_gnt),
    .o_any     (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_idata   <= '0;
      r_drdata  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_ivalid  <= 1'b0;
      r_dvalid  <= 1'b0;
      r_ierr    <= 1'b0;
      r_derr    <= 1'b0;
      r_busy_ti <= 1'b0;
      r_busy_td <= 1'b0;
    end else begin
      r_ierr <= 1'b0;
      r_derr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            if (w_gnt == GNT_D) begin
              r_busy_ti <= 1'b1;
              r_addr    <= d_addr;
              r_wdata   <= d_wdata;
              r_wstrb   <= d_wstrb;
              if (d_write_ena) begin
                r_state   <= D_AW;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
              end else begin
                r_state   <= D_AR;
                r_arvalid <= 1'b1;
              end
            end else begin
              r_busy_td <= 1'b1;
              r_addr    <= i_addr;
              r_state   <= I_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        I_AR, D_AR: begin
          if (m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= (r_state == I_AR) ? I_R : D_R;
          end
        end
        I_R: begin
          if (m_rvalid) begin
            r_rready <= 1'b0;
            r_idata  <= m_rdata;
            r_ierr   <= resp_is_err(m_rresp);
            r_ivalid <= 1'b1;
            r_state  <= I_DONE;
          end
        end
        D_R: begin
          if (m_rvalid) begin
            r_rready <= 1'b0;
            r_drdata <= m_rdata;
            r_derr   <= resp_is_err(m_rresp);
            r_dvalid <= 1'b1;
            r_state  <= D_DONE;
          end
        end
        D_AW: begin
          if (m_awready) r_awvalid <= 1'b0;
          if (m_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= D_B;
          end
        end
        D_B: begin
          if (m_bvalid) begin
            r_bready <= 1'b0;
            r_derr   <= resp_is_err(m_bresp);
            r_dvalid <= 1'b1;
            r_state  <= D_DONE;
          end
        end
        I_DONE: begin
          if (i_read_resp) begin
            r_ivalid  <= 1'b0;
            r_busy_td <= 1'b0;
            r_state   <= IDLE;
          end
        end
        D_DONE: begin
          if (d_resp) begin
            r_dvalid  <= 1'b0;
            r_busy_ti <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_data         = r_idata;
  assign i_valid        = r_ivalid;
  assign i_err          = r_ierr;
  assign d_rdata        = r_drdata;
  assign d_valid        = r_dvalid;
  assign d_err          = r_derr;
  assign arb_working_ti = r_busy_ti;
  assign arb_working_td = r_busy_td;
  assign m_araddr       = r_addr;
  assign m_arvalid      = r_arvalid;
  assign m_rready       = r_rready;
  assign m_awaddr       = r_addr;
  assign m_awvalid      = r_awvalid;
  assign m_wdata        = r_wdata;
  assign m_wstrb        = r_wstrb;
  assign m_wvalid       = r_wvalid;
  assign m_bready       = r_bready;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_cache_mem_arbiter : scoreboard bench, RR and fixed-priority instances |
// | Revision             : 1.0                                               |
// +------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_cache_mem_arbiter;

  typedef struct {
    logic [63:0] addr;
    bit          wr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  typedef struct {
    bit          is_d;
    bit          is_wr;
    logic [63:0] data;
    bit          err;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        i_read_ena, i_read_resp, d_read_ena, d_write_ena, d_resp;
  logic [63:0] i_addr, d_addr, d_wdata;
  logic [7:0]  d_wstrb;
  logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;

  logic [63:0] x_i_data[2], x_d_rdata[2], x_araddr[2], x_awaddr[2], x_wdata[2];
  logic [7:0]  x_wstrb[2];
  logic        x_i_valid[2], x_d_valid[2], x_ti[2], x_td[2], x_ierr[2], x_derr[2];
  logic        x_arvalid[2], x_rready[2], x_awvalid[2], x_wvalid[2], x_bready[2];

  // Instance 0 runs round-robin, instance 1 fixed d priority; sel picks which one is observed.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    cache_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(g == 0 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .i_read_ena(i_read_ena), .i_addr(i_addr), .i_data(x_i_data[g]), .i_valid(x_i_valid[g]),
      .i_read_resp(i_read_resp), .arb_working_ti(x_ti[g]),
      .d_read_ena(d_read_ena), .d_write_ena(d_write_ena), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(x_d_rdata[g]), .d_valid(x_d_valid[g]), .d_resp(d_resp),
      .arb_working_td(x_td[g]), .d_err(x_derr[g]), .i_err(x_ierr[g]),
      .m_araddr(x_araddr[g]), .m_arvalid(x_arvalid[g]), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(x_rready[g]),
      .m_awaddr(x_awaddr[g]), .m_awvalid(x_awvalid[g]), .m_awready(m_awready),
      .m_wdata(x_wdata[g]), .m_wstrb(x_wstrb[g]), .m_wvalid(x_wvalid[g]), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(x_bready[g])
    );
  end

  wire [63:0] w_i_data   = x_i_data[sel];
  wire [63:0] w_d_rdata  = x_d_rdata[sel];
  wire [63:0] w_araddr   = x_araddr[sel];
  wire [63:0] w_awaddr   = x_awaddr[sel];
  wire [63:0] w_wdata    = x_wdata[sel];
  wire [7:0]  w_wstrb    = x_wstrb[sel];
  wire        w_i_valid  = x_i_valid[sel];
  wire        w_d_valid  = x_d_valid[sel];
  wire        w_ti       = x_ti[sel];
  wire        w_td       = x_td[sel];
  wire        w_ierr     = x_ierr[sel];
  wire        w_derr     = x_derr[sel];
  wire        w_arvalid  = x_arvalid[sel];
  wire        w_rready   = x_rready[sel];
  wire        w_awvalid  = x_awvalid[sel];
  wire        w_wvalid   = x_wvalid[sel];
  wire        w_bready   = x_bready[sel];

  int   n_tests, n_fail, n_aw, n_w, n_ti_viol;
  int   ist, dst, i_ack_delay, d_ack_delay;
  int   ar_delay, aw_delay, w_delay;
  logic r_hold;
  logic [1:0]  rresp_val;
  logic [63:0] wr_addr, wr_data;
  logic [7:0]  wr_strb;
  req_t iq[$], dq[$];
  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    case (a)
      64'h0000_0000_8000_0010: return 64'h1234_5678_9ABC_DEF0;
      64'h0000_0000_8000_0200: return 64'h0BAD_F00D_0000_0001;
      64'h0000_0000_8000_0300: return 64'h1111_2222_3333_4444;
      default:                 return {32'hA5A5_0000, a[31:0]};
    endcase
  endfunction

  // AXI slave: ready after a programmable wait, one-beat read/response one cycle after address.
  initial begin : slave
    bit pend_r, pend_b, aw_got, w_got;
    int ar_cnt, aw_cnt, w_cnt;
    logic [63:0] rd_addr;
    m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
    m_rdata = '0; m_rresp = '0; m_bresp = '0;
    pend_r = 0; pend_b = 0; aw_got = 0; w_got = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    rd_addr = '0;
    forever begin
      @(posedge clk); #1;
      m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      if (!rst) begin
        pend_r = 0; pend_b = 0; aw_got = 0; w_got = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (pend_r && !r_hold) begin
          m_rvalid = 1; m_rdata = mem_read(rd_addr); m_rresp = rresp_val;
          if (w_rready) pend_r = 0;
        end
        if (w_arvalid && !pend_r) begin
          if (ar_cnt >= ar_delay) begin
            m_arready = 1; pend_r = 1; rd_addr = w_araddr; ar_cnt = 0;
          end else ar_cnt++;
        end
        if (pend_b) begin
          m_bvalid = 1; m_bresp = 2'b00;
          if (w_bready) pend_b = 0;
        end
        if (w_awvalid && !aw_got) begin
          if (aw_cnt >= aw_delay) begin
            m_awready = 1; aw_got = 1; wr_addr = w_awaddr; aw_cnt = 0;
          end else aw_cnt++;
        end
        if (w_wvalid && !w_got) begin
          if (w_cnt >= w_delay) begin
            m_wready = 1; w_got = 1; wr_data = w_wdata; wr_strb = w_wstrb; w_cnt = 0;
          end else w_cnt++;
        end
        if (aw_got && w_got) begin
          pend_b = 1; aw_got = 0; w_got = 0;
        end
      end
    end
  end

  // icache requester: holds ena until i_valid, then acknowledges after i_ack_delay cycles.
  initial begin : ireq
    req_t rq;
    int cnt;
    i_read_ena = 0; i_read_resp = 0; i_addr = '0; ist = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        i_read_ena = 0; i_read_resp = 0; ist = 0;
      end else begin
        case (ist)
          0: if (iq.size() != 0) begin
               rq = iq.pop_front(); i_addr = rq.addr; i_read_ena = 1; ist = 1;
             end
          1: if (w_i_valid) begin i_read_ena = 0; cnt = 0; ist = 2; end
          2: if (cnt >= i_ack_delay) begin i_read_resp = 1; ist = 3; end else cnt++;
          default: begin i_read_resp = 0; ist = 0; end
        endcase
      end
    end
  end

  initial begin : dreq
    req_t rq;
    int cnt;
    d_read_ena = 0; d_write_ena = 0; d_resp = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    dst = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        d_read_ena = 0; d_write_ena = 0; d_resp = 0; dst = 0;
      end else begin
        case (dst)
          0: if (dq.size() != 0) begin
               rq = dq.pop_front(); d_addr = rq.addr; d_wdata = rq.wdata; d_wstrb = rq.wstrb;
               if (rq.wr) d_write_ena = 1; else d_read_ena = 1;
               dst = 1;
             end
          1: if (w_d_valid) begin d_read_ena = 0; d_write_ena = 0; cnt = 0; dst = 2; end
          2: if (cnt >= d_ack_delay) begin d_resp = 1; dst = 3; end else cnt++;
          default: begin d_resp = 0; dst = 0; end
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every rising i_valid / d_valid.
  initial begin : monitor
    bit prev_iv, prev_dv;
    exp_t e;
    prev_iv = 0; prev_dv = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_iv = 0; prev_dv = 0;
      end else begin
        if (w_awvalid) n_aw++;
        if (w_wvalid)  n_w++;
        if ((w_awvalid || w_wvalid || w_bready || w_d_valid) && !w_ti) n_ti_viol++;
        if ((w_i_valid && !prev_iv) || (w_d_valid && !prev_dv)) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_valid: i_valid=%0b d_valid=%0b with empty scoreboard", w_i_valid, w_d_valid);
          end else begin
            e = sb.pop_front();
            chk("served_side_is_d", {63'd0, w_d_valid}, {63'd0, e.is_d});
            if (!e.is_d) begin
              chk("i_data", w_i_data, e.data);
              chk("i_err", {63'd0, w_ierr}, {63'd0, e.err});
            end else if (e.is_wr) begin
              chk("wr_addr", wr_addr, e.waddr);
              chk("wr_data", wr_data, e.wdata);
              chk("wr_strb", {56'd0, wr_strb}, {56'd0, e.wstrb});
              chk("d_err_wr", {63'd0, w_derr}, {63'd0, e.err});
            end else begin
              chk("d_rdata", w_d_rdata, e.data);
              chk("d_err_rd", {63'd0, w_derr}, {63'd0, e.err});
            end
          end
        end
        prev_iv = w_i_valid;
        prev_dv = w_d_valid;
      end
    end
  end

  task automatic req_i(input logic [63:0] a);
    iq.push_back('{addr: a, wr: 1'b0, wdata: '0, wstrb: '0});
  endtask

  task automatic req_d(input logic [63:0] a, input bit wr, input logic [63:0] wd, input logic [7:0] ws);
    dq.push_back('{addr: a, wr: wr, wdata: wd, wstrb: ws});
  endtask

  task automatic exp_rd(input bit is_d, input logic [63:0] data, input bit err);
    sb.push_back('{is_d: is_d, is_wr: 1'b0, data: data, err: err, waddr: '0, wdata: '0, wstrb: '0});
  endtask

  task automatic exp_wr(input logic [63:0] a, input logic [63:0] wd, input logic [7:0] ws);
    sb.push_back('{is_d: 1'b1, is_wr: 1'b1, data: '0, err: 1'b0, waddr: a, wdata: wd, wstrb: ws});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(sb.size() == 0 && iq.size() == 0 && dq.size() == 0 && ist == 0 && dst == 0 &&
                 !w_i_valid && !w_d_valid) && k < budget);
    if (k >= budget) tmo(name);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k, a0, w0, v0;
    logic [63:0] rr0_d[3], rr0_i[3];
    n_tests = 0; n_fail = 0; n_aw = 0; n_w = 0; n_ti_viol = 0;
    sel = 0; rst = 0; r_hold = 0; rresp_val = 2'b00;
    ar_delay = 0; aw_delay = 0; w_delay = 0; i_ack_delay = 1; d_ack_delay = 1;
    wr_addr = '0; wr_data = '0; wr_strb = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {53'd0, w_i_valid, w_d_valid, w_ti, w_td, w_ierr, w_derr,
                       w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready}, 64'd0);
    chk("reset_data", w_i_data | w_d_rdata | w_araddr | w_awaddr | w_wdata | {56'd0, w_wstrb}, 64'd0);
    rst = 1;
    repeat (2) @(negedge clk);

    // dcache write: awready after 2 waits, wready immediate
    aw_delay = 2; w_delay = 0;
    a0 = n_aw; w0 = n_w; v0 = n_ti_viol;
    req_d(64'h8000_0100, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    exp_wr(64'h8000_0100, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    wait_idle("dwrite", 60);
    chk("awvalid_cycles", 64'(n_aw - a0), 64'd3);
    chk("wvalid_cycles", 64'(n_w - w0), 64'd1);
    chk("ti_busy_during_write", 64'(n_ti_viol - v0), 64'd0);
    aw_delay = 0;

    // icache only, zero wait, cycle-exact
    i_ack_delay = 2;
    @(negedge clk);
    req_i(64'h8000_0010);
    exp_rd(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("c0_idle", {62'd0, w_td, w_i_valid}, 64'd0);
    @(negedge clk);
    chk("c1_td_arvalid", {62'd0, w_td, w_arvalid}, 64'd3);
    @(negedge clk);
    chk("c2_td_rready", {61'd0, w_td, w_rready, w_i_valid}, 64'd6);
    @(negedge clk);
    chk("c3_i_valid", {63'd0, w_i_valid}, 64'd1);
    repeat (2) @(negedge clk);
    chk("c5_i_valid_held", {63'd0, w_i_valid}, 64'd1);
    chk("c5_i_data_held", w_i_data, 64'h1234_5678_9ABC_DEF0);
    wait_idle("ionly", 40);
    i_ack_delay = 1;

    // Round-robin: last grant is i, so d goes first
    @(negedge clk);
    req_d(64'h8000_0420, 1'b0, '0, '0);
    req_i(64'h8000_0410);
    exp_rd(1'b1, 64'hA5A5_0000_8000_0420, 1'b0);
    exp_rd(1'b0, 64'hA5A5_0000_8000_0410, 1'b0);
    wait_idle("rr_pair1", 60);
    // A d-only read leaves last grant on d, so the next pair starts with i
    req_d(64'h8000_0300, 1'b0, '0, '0);
    exp_rd(1'b1, 64'h1111_2222_3333_4444, 1'b0);
    wait_idle("d_only", 40);
    req_d(64'h8000_0440, 1'b0, '0, '0);
    req_i(64'h8000_0430);
    exp_rd(1'b0, 64'hA5A5_0000_8000_0430, 1'b0);
    exp_rd(1'b1, 64'hA5A5_0000_8000_0440, 1'b0);
    wait_idle("rr_pair2", 60);

    // SLVERR on an i read
    rresp_val = 2'b10; i_ack_delay = 2;
    req_i(64'h8000_0200);
    exp_rd(1'b0, 64'h0BAD_F00D_0000_0001, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!w_i_valid && k < 30);
    if (k >= 30) tmo("err_valid");
    chk("i_err_first", {63'd0, w_ierr}, 64'd1);
    @(negedge clk);
    chk("i_err_pulse_end", {62'd0, w_ierr, w_i_valid}, 64'd1);
    wait_idle("err", 40);
    rresp_val = 2'b00; i_ack_delay = 1;

    // Reset while in D_R with rvalid withheld
    r_hold = 1;
    req_d(64'h8000_0800, 1'b0, '0, '0);
    k = 0;
    do begin @(negedge clk); k++; end while (!w_rready && k < 30);
    if (k >= 30) tmo("reach_d_r");
    chk("in_d_r", {62'd0, w_ti, w_rready}, 64'd3);
    #2 rst = 0;
    #1;
    chk("async_rst_ctrl", {58'd0, w_ti, w_td, w_rready, w_arvalid, w_d_valid, w_i_valid}, 64'd0);
    chk("async_rst_data", w_d_rdata | w_i_data | w_araddr, 64'd0);
    repeat (2) @(negedge clk);
    r_hold = 0;
    rst = 1;
    @(negedge clk);
    req_i(64'h8000_0010);
    exp_rd(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    wait_idle("post_reset_i", 40);

    // Fixed d priority instance: three simultaneous pairs, d always first
    rr0_d[0] = 64'h8000_0600; rr0_d[1] = 64'h8000_0610; rr0_d[2] = 64'h8000_0620;
    rr0_i[0] = 64'h8000_0700; rr0_i[1] = 64'h8000_0710; rr0_i[2] = 64'h8000_0720;
    sel = 1;
    pulse_reset();
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      req_d(rr0_d[p], 1'b0, '0, '0);
      req_i(rr0_i[p]);
      exp_rd(1'b1, {32'hA5A5_0000, rr0_d[p][31:0]}, 1'b0);
      exp_rd(1'b0, {32'hA5A5_0000, rr0_i[p][31:0]}, 1'b0);
      wait_idle("fixed_pair", 60);
    end

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
